adv7513_reg_dump: RTL

//  Register-dump sequencer placed directly upstream of the ADV7513 single-register I2C reader.
//  On one trigger it walks an address range and issues one read per address to the reader.

---
 rtl/adv7513_reg_dump.sv | 106 ++++++++++
 1 files changed

// File: rtl/adv7513_reg_dump.sv
// adv7513_reg_dump: walks an ADV7513 register range through a single-register reader into a host-readable 256x8 buffer.
// Define ADV7513_DUMP_DIFF_EN to track which registers changed since the previous dump.
module adv7513_reg_dump #(
  parameter logic [7:0]  START_ADDR     = 8'h00,
  parameter logic [7:0]  END_ADDR       = 8'hFF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dump_start,
  output logic       dump_busy,
  output logic       dump_done,
  output logic       dump_err,
  output logic [8:0] reg_count,
  output logic       rd_start,
  output logic [7:0] rd_addr,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       host_changed,
  output logic [8:0] diff_count
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WLOW, S_WHIGH, S_STORE, S_DONE} state_t;
  state_t state, nxt;
  logic [23:0] tmo;
  logic [7:0] data_q;
  logic [7:0] mem [256];
  logic tmo_hit, accept, store, waiting;
  assign tmo_hit = tmo == '0;
  assign accept = state == S_IDLE && dump_start;
  assign store = state == S_STORE;
  assign waiting = state == S_WLOW || state == S_WHIGH;
  assign dump_busy = state != S_IDLE;
  assign dump_done = state == S_DONE;
  assign rd_start = state == S_ISSUE;
  // A done level still high from the previous read must fall before we look for the rising one.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = dump_start ? S_ISSUE : S_IDLE;
      S_ISSUE: nxt = S_WLOW;
      S_WLOW:  nxt = tmo_hit ? S_DONE : rd_done ? S_WLOW : S_WHIGH;
      S_WHIGH: nxt = tmo_hit ? S_DONE : rd_done ? S_STORE : S_WHIGH;
      S_STORE: nxt = rd_addr == END_ADDR ? S_DONE : S_ISSUE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      tmo <= '0;
      rd_addr <= START_ADDR;
      reg_count <= '0;
      dump_err <= 1'b0;
      data_q <= '0;
      host_data <= '0;
    end else begin
      state <= nxt;
      host_data <= mem[host_addr];
      if (accept) begin
        dump_err <= 1'b0;
        reg_count <= '0;
        rd_addr <= START_ADDR;
      end
      if (rd_start) tmo <= TIMEOUT_CYCLES;
      else if (waiting) begin
        tmo <= tmo - 24'd1;
        if (tmo_hit) dump_err <= 1'b1;
      end
      if (state == S_WHIGH) data_q <= rd_data;
      if (store) begin
        reg_count <= reg_count + 9'd1;
        if (rd_addr != END_ADDR) rd_addr <= rd_addr + 8'd1;
      end
    end
  always_ff @(posedge clk)
    if (store) mem[rd_addr] <= data_q;
`ifdef ADV7513_DUMP_DIFF_EN
  logic [255:0] valid, changed;
  logic [7:0] old_q;
  logic diff;
  assign diff = valid[rd_addr] && old_q != data_q;
  // rd_addr is stable from issue to store, so this holds the pre-store byte by S_STORE.
  always_ff @(posedge clk)
    old_q <= mem[rd_addr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= '0;
      changed <= '0;
      diff_count <= '0;
      host_changed <= 1'b0;
    end else begin
      host_changed <= changed[host_addr];
      if (accept) diff_count <= '0;
      if (store) begin
        valid[rd_addr] <= 1'b1;
        changed[rd_addr] <= diff;
        diff_count <= diff_count + 9'(diff);
      end
    end
`else
  assign host_changed = 1'b0;
  assign diff_count = '0;
`endif
endmodule
